// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the restoring divider: FSM state encoding,
//   default operand widths and the iteration counter width.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 17;
  localparam int DIVISOR_W_DEF  = 16;
  localparam int CNT_W          = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/trial_subtractor.sv
// trial_subtractor
//   Combinational trial subtraction for one restoring-division step.
//   Ports:
//     minuend     in   W   shifted partial remainder
//     subtrahend  in   W   zero-extended divisor
//     difference  out  W   minuend - subtrahend (valid when no_borrow=1)
//     no_borrow   out  1   1 when minuend >= subtrahend, i.e. keep the difference
module trial_subtractor #(
  parameter int W = 17
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] difference,
  output logic         no_borrow
);

  logic borrow;

  // One extra bit on the subtraction exposes the borrow out; no borrow
  // means the trial succeeded and the quotient bit is a 1.
  assign {borrow, difference} = {1'b0, minuend} - {1'b0, subtrahend};
  assign no_borrow = ~borrow;

endmodule

// File: rtl/restoring_divider.sv
// restoring_divider
//   Iterative unsigned restoring divider, one quotient bit per clock, MSB
//   first. One division per Run assertion; a held Run never restarts.
//   Ports:
//     Clk          in   1           system clock, rising edge
//     Reset_Clear  in   1           asynchronous active-low reset
//     Run          in   1           active-high start level
//     Dividend     in   DIVIDEND_W  sampled on the start cycle only
//     Divisor      in   DIVISOR_W   sampled on the start cycle only
//     Quotient     out  DIVIDEND_W  result, held until next completion
//     Remainder    out  DIVISOR_W   result, held until next completion
//     Busy         out  1           high while in CALC
//     Done         out  1           high while in DONE
//     DivByZero    out  1           set when the last result had Divisor==0
//   Configuration macro:
//     DIV_FAST_PATH_EN  when defined, Dividend<Divisor finishes in one edge
module restoring_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset_Clear,
  input  logic                  Run,
  input  logic [DIVIDEND_W-1:0] Dividend,
  input  logic [DIVISOR_W-1:0]  Divisor,
  output logic [DIVIDEND_W-1:0] Quotient,
  output logic [DIVISOR_W-1:0]  Remainder,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivByZero
);

  localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

  div_state_t state;
  div_state_t next_state;

  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVISOR_W-1:0]  d_reg;
  logic [DIVISOR_W:0]    p_reg;
  logic [CNT_BITS-1:0]   cnt;

  logic [DIVISOR_W:0]    p_shift;
  logic [DIVISOR_W:0]    p_diff;
  logic [DIVISOR_W:0]    p_next;
  logic [DIVIDEND_W-1:0] q_next;
  logic                  no_borrow;
  logic                  start_zero;
  logic                  start_fast;
  logic                  last_step;
  logic                  unused_p_msb;

  // After every step the partial remainder is below the divisor, so its top
  // bit is always 0 going into the next shift; it is kept only so the stored
  // value matches the full-width step result.
  assign unused_p_msb = p_reg[DIVISOR_W];

  // Shift the next dividend bit into the partial remainder and trial-subtract
  // the divisor; the borrow decides between keeping the difference or restoring.
  assign p_shift = {p_reg[DIVISOR_W-1:0], q_reg[DIVIDEND_W-1]};

  trial_subtractor #(
    .W(DIVISOR_W + 1)
  ) u_trial_subtractor (
    .minuend   (p_shift),
    .subtrahend({1'b0, d_reg}),
    .difference(p_diff),
    .no_borrow (no_borrow)
  );

  assign p_next    = no_borrow ? p_diff : p_shift;
  assign q_next    = {q_reg[DIVIDEND_W-2:0], no_borrow};
  assign last_step = (cnt == CNT_BITS'(1));
  assign start_zero = (Divisor == '0);

  // With the fast path, a dividend smaller than the divisor has an obvious
  // answer (quotient 0, remainder = dividend), so the iterations are skipped.
`ifdef DIV_FAST_PATH_EN
  assign start_fast = !start_zero && (Dividend < DIVIDEND_W'(Divisor));
`else
  assign start_fast = 1'b0;
`endif

  // State register; an asynchronous reset aborts any division in flight.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and status decode. Run is ignored during CALC, and DONE waits
  // for Run to drop so that a held button produces only one division.
  always_comb begin
    next_state = state;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      IDLE: begin
        if (Run) begin
          next_state = (start_zero || start_fast) ? DONE : CALC;
        end
      end
      CALC: begin
        Busy = 1'b1;
        if (last_step) begin
          next_state = DONE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operands are captured on the start cycle, one quotient bit is
  // produced per CALC cycle, and the result registers only change on
  // completion so the displays hold the previous answer during a division.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      q_reg     <= '0;
      d_reg     <= '0;
      p_reg     <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            q_reg <= Dividend;
            d_reg <= Divisor;
            p_reg <= '0;
            cnt   <= CNT_BITS'(DIVIDEND_W);
            if (start_zero) begin
              Quotient  <= '1;
              Remainder <= Dividend[DIVISOR_W-1:0];
              DivByZero <= 1'b1;
            end else if (start_fast) begin
              Quotient  <= '0;
              Remainder <= Dividend[DIVISOR_W-1:0];
              DivByZero <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg <= q_next;
          p_reg <= p_next;
          cnt   <= cnt - CNT_BITS'(1);
          if (last_step) begin
            Quotient  <= q_next;
            Remainder <= p_next[DIVISOR_W-1:0];
            DivByZero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
